// File: rtl/vga_timing_pkg.sv
// Shared geometry constants and width helper for the VGA raster timing generator.
// Default geometry is 640x480@60; a reduced 320x240 geometry is provided for bring-up.
package vga_timing_pkg;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } vga_axis_t;

   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
   } vga_geom_t;

   localparam vga_geom_t VGA_640X480 = '{
      h: '{active: 640, fp: 16, sync: 96, bp: 48},
      v: '{active: 480, fp: 10, sync: 2,  bp: 33}
   };

   localparam vga_geom_t VGA_320X240 = '{
      h: '{active: 320, fp: 8, sync: 32, bp: 40},
      v: '{active: 240, fp: 3, sync: 4,  bp: 15}
   };

   localparam int VGA_DEF_CLK_DIV = 2;
   localparam int VGA_DEF_CW      = 11;

   // Smallest counter width able to hold max(h_total, v_total) - 1.
   function automatic int vga_cw_req(input int h_total, input int v_total);
      int max_cnt;
      int w;
      max_cnt = ((h_total > v_total) ? h_total : v_total) - 1;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) <= max_cnt) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider: one-clock pix_en strobe every CLK_DIV system clocks.
// The strobe is masked by en and reset so a frozen or resetting divider never issues a pixel.
module pix_clk_en #(
   parameter int CLK_DIV = 2
) (
   input  logic clk50,
   input  logic reset,
   input  logic en,
   output logic pix_en
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   always_comb begin
      div_d = div_q;
      if (en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign pix_en = en && !reset && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: raster counters plus a one-pixel-late
// output register carrying coordinates, syncs, data-enable and frame/line strobes.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = VGA_DEF_CLK_DIV,
   parameter int CW       = VGA_DEF_CW,
   parameter int H_ACTIVE = VGA_640X480.h.active,
   parameter int H_FP     = VGA_640X480.h.fp,
   parameter int H_SYNC   = VGA_640X480.h.sync,
   parameter int H_BP     = VGA_640X480.h.bp,
   parameter int V_ACTIVE = VGA_640X480.v.active,
   parameter int V_FP     = VGA_640X480.v.fp,
   parameter int V_SYNC   = VGA_640X480.v.sync,
   parameter int V_BP     = VGA_640X480.v.bp,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic          clk50,
   input  logic          reset,
   input  logic          en,
   output logic          pix_en,
   output logic          vga_h_sync,
   output logic          vga_v_sync,
   output logic          de,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [CW-1:0] next_x,
   output logic [CW-1:0] next_y,
   output logic          line_start,
   output logic          frame_start,
   output logic          vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   if (CLK_DIV < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 ||
       CW < vga_cw_req(H_TOTAL, V_TOTAL)) begin : g_bad_cfg
      $fatal(1, "vga_timing_gen: counter width or geometry parameters invalid");
   end

   logic          pix_en_w;
   logic [CW-1:0] cx_q, cx_d;
   logic [CW-1:0] cy_q, cy_d;
   logic [CW-1:0] pix_x_q, pix_y_q;
   logic          de_q, hs_q, vs_q, vblank_q;
   logic          line_start_q, frame_start_q;
   logic          hs_act, vs_act;

   pix_clk_en #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_clk_en (
      .clk50  (clk50),
      .reset  (reset),
      .en     (en),
      .pix_en (pix_en_w)
   );

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (pix_en_w) begin
         if (cx_q == H_LAST) begin
            cx_d = '0;
            cy_d = (cy_q == V_LAST) ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
   end

   assign hs_act = (cx_q >= HS_BEG) && (cx_q <= HS_END);
   assign vs_act = (cy_q >= VS_BEG) && (cy_q <= VS_END);

   // Output register samples the pre-increment counters, so it trails next_* by one pixel.
   always_ff @(posedge clk50) begin
      if (reset) begin
         cx_q          <= '0;
         cy_q          <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         de_q          <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         vblank_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         line_start_q  <= pix_en_w && (cx_q == '0);
         frame_start_q <= pix_en_w && (cx_q == '0) && (cy_q == '0);
         if (pix_en_w) begin
            pix_x_q  <= cx_q;
            pix_y_q  <= cy_q;
            de_q     <= (cx_q < H_ACT) && (cy_q < V_ACT);
            hs_q     <= hs_act ? HS_POL : ~HS_POL;
            vs_q     <= vs_act ? VS_POL : ~VS_POL;
            vblank_q <= (cy_q >= V_ACT);
         end
      end
   end

   assign pix_en      = pix_en_w;
   assign vga_h_sync  = hs_q;
   assign vga_v_sync  = vs_q;
   assign de          = de_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign next_x      = cx_q;
   assign next_y      = cy_q;
   assign vblank      = vblank_q;
   // Strobes stay quiet while the generator is frozen.
   assign line_start  = line_start_q && en;
   assign frame_start = frame_start_q && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 14x8 raster checked against a pixel-index model
// through a scoreboard, plus a default-geometry CLK_DIV=1 instance with positive hsync.
module tb_vga_timing_gen;

   localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 1;
   localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
   localparam int H_T = H_A + H_F + H_S + H_B;
   localparam int V_T = V_A + V_F + V_S + V_B;
   localparam int DIV = 2;
   localparam int HS0 = H_A + H_F;
   localparam int VS0 = V_A + V_F;

   logic       clk;
   logic       rst, en;
   logic       pix_en, hs, vs, de, ls, fs, vb;
   logic [3:0] px, py, nx, ny;

   logic        rst2, en2;
   logic        pix_en2, hs2, vs2, de2, ls2, fs2, vb2;
   logic [10:0] px2, py2, nx2, ny2;

   int total = 0;
   int bad   = 0;
   int cnt   = 0;
   int last_ls = -1;
   int last_fs = -1;
   bit rules_on = 1'b0;
   bit def_done = 1'b0;

   typedef struct {
      logic       pe, ls, fs, de, hs, vs, vb;
      logic [3:0] px, py, nx, ny;
   } exp_t;
   exp_t sb[$];

   int         m_div, m_n;
   logic [3:0] m_px, m_py;
   logic       m_de, m_hs, m_vs, m_vb, m_lsq, m_fsq;

   vga_timing_gen #(
      .CLK_DIV(DIV), .CW(4),
      .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
      .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk50(clk), .reset(rst), .en(en), .pix_en(pix_en),
      .vga_h_sync(hs), .vga_v_sync(vs), .de(de),
      .pix_x(px), .pix_y(py), .next_x(nx), .next_y(ny),
      .line_start(ls), .frame_start(fs), .vblank(vb)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .HS_POL(1'b1)
   ) dut_def (
      .clk50(clk), .reset(rst2), .en(en2), .pix_en(pix_en2),
      .vga_h_sync(hs2), .vga_v_sync(vs2), .de(de2),
      .pix_x(px2), .pix_y(py2), .next_x(nx2), .next_y(ny2),
      .line_start(ls2), .frame_start(fs2), .vblank(vb2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cnt);
      end
   endtask

   // Drive one clock of stimulus, predict the post-edge outputs, then compare.
   task automatic cyc(input logic r, input logic e);
      exp_t x;
      int   cx, cy;
      logic pe;
      @(negedge clk);
      rst = r;
      en  = e;
      pe  = e && !r && (m_div == DIV - 1);
      if (r) begin
         m_div = 0; m_n = 0; m_px = '0; m_py = '0;
         m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_vb = 1'b0;
         m_lsq = 1'b0; m_fsq = 1'b0;
      end else begin
         cx = m_n % H_T;
         cy = m_n / H_T;
         m_lsq = pe && (cx == 0);
         m_fsq = pe && (m_n == 0);
         if (pe) begin
            m_px = 4'(cx);
            m_py = 4'(cy);
            m_de = (cx < H_A) && (cy < V_A);
            m_hs = !((cx >= HS0) && (cx < HS0 + H_S));
            m_vs = !((cy >= VS0) && (cy < VS0 + V_S));
            m_vb = (cy >= V_A);
            m_n  = (m_n + 1) % (H_T * V_T);
         end
         if (e) m_div = (m_div + 1) % DIV;
      end
      x.pe = e && !r && (m_div == DIV - 1);
      x.ls = m_lsq && e;
      x.fs = m_fsq && e;
      x.de = m_de; x.hs = m_hs; x.vs = m_vs; x.vb = m_vb;
      x.px = m_px; x.py = m_py;
      x.nx = 4'(m_n % H_T);
      x.ny = 4'(m_n / H_T);
      sb.push_back(x);

      @(posedge clk);
      #1;
      cnt++;
      x = sb.pop_front();
      chk("pix_en", 32'(pix_en), 32'(x.pe));
      chk("line_start", 32'(ls), 32'(x.ls));
      chk("frame_start", 32'(fs), 32'(x.fs));
      chk("de", 32'(de), 32'(x.de));
      chk("h_sync", 32'(hs), 32'(x.hs));
      chk("v_sync", 32'(vs), 32'(x.vs));
      chk("vblank", 32'(vb), 32'(x.vb));
      chk("pix_x", 32'(px), 32'(x.px));
      chk("pix_y", 32'(py), 32'(x.py));
      chk("next_x", 32'(nx), 32'(x.nx));
      chk("next_y", 32'(ny), 32'(x.ny));

      if (rules_on) begin
         chk("de_rule", 32'(de), 32'(px < 4'd8 && py < 4'd4));
         chk("hs_rule", 32'(hs), 32'(!(px == 4'd10 || px == 4'd11 || px == 4'd12)));
         chk("vs_rule", 32'(vs), 32'(!(py == 4'd5 || py == 4'd6)));
         chk("vb_rule", 32'(vb), 32'(py >= 4'd4));
         chk("x_range", 32'(px < 4'd14), 32'd1);
         chk("y_range", 32'(py < 4'd8), 32'd1);
      end
      if (ls) begin
         if (last_ls >= 0) chk("line_period", 32'(cnt - last_ls), 32'd28);
         last_ls = cnt;
      end
      if (fs) begin
         if (last_fs >= 0) chk("frame_period", 32'(cnt - last_fs), 32'd224);
         last_fs = cnt;
      end
   endtask

   initial begin
      int first;
      rst = 1'b1;
      en  = 1'b1;

      repeat (5) begin
         cyc(1'b1, 1'b1);
         chk("rst_hs", 32'(hs), 32'd1);
         chk("rst_vs", 32'(vs), 32'd1);
      end

      first = -1;
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1);
         if (pix_en && first < 0) first = k + 1;
         if (k == 2) begin
            chk("rel_fs", 32'(fs), 32'd1);
            chk("rel_px", 32'(px), 32'd0);
            chk("rel_py", 32'(py), 32'd0);
            chk("rel_de", 32'(de), 32'd1);
         end
      end
      chk("first_pix_en_clk", 32'(first), 32'd2);
      rules_on = 1'b1;

      repeat (2 * H_T * V_T * DIV) cyc(1'b0, 1'b1);

      for (int i = 0; i < 40 && px != 4'd5; i++) cyc(1'b0, 1'b1);
      chk("stall_reach", 32'(px), 32'd5);
      repeat (7) begin
         cyc(1'b0, 1'b0);
         chk("stall_px", 32'(px), 32'd5);
         chk("stall_pe", 32'(pix_en), 32'd0);
      end
      last_ls = -1;
      last_fs = -1;
      for (int i = 0; i < 6 && px == 4'd5; i++) cyc(1'b0, 1'b1);
      chk("resume_px", 32'(px), 32'd6);

      for (int i = 0; i < 300 && !(py == 4'd3 && px == 4'd9); i++) cyc(1'b0, 1'b1);
      chk("mid_reach", 32'(py == 4'd3 && px == 4'd9), 32'd1);
      rules_on = 1'b0;
      cyc(1'b1, 1'b1);
      chk("mid_rst_px", 32'(px), 32'd0);
      chk("mid_rst_nx", 32'(nx), 32'd0);
      chk("mid_rst_ny", 32'(ny), 32'd0);
      chk("mid_rst_de", 32'(de), 32'd0);
      chk("mid_rst_hs", 32'(hs), 32'd1);
      last_ls = -1;
      last_fs = -1;
      for (int i = 0; i < 6 && !fs; i++) cyc(1'b0, 1'b1);
      chk("restart_fs", 32'(fs), 32'd1);
      chk("restart_px", 32'(px), 32'd0);
      chk("restart_py", 32'(py), 32'd0);
      rules_on = 1'b1;
      repeat (H_T * V_T * DIV) cyc(1'b0, 1'b1);

      for (int i = 0; i < 3000 && !def_done; i++) @(posedge clk);
      chk("def_timeout", 32'(def_done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int last, hs_cnt;
      rst2 = 1'b1;
      en2  = 1'b1;
      repeat (3) @(negedge clk);
      rst2 = 1'b0;
      last = -1;
      hs_cnt = 0;
      for (int k = 0; k < 1700; k++) begin
         @(posedge clk);
         #1;
         chk("def_pix_en", 32'(pix_en2), 32'd1);
         chk("def_hs", 32'(hs2), 32'(px2 >= 11'd656 && px2 <= 11'd751));
         chk("def_vs", 32'(vs2), 32'd1);
         chk("def_de", 32'(de2), 32'(px2 < 11'd640 && py2 < 11'd480));
         chk("def_vb", 32'(vb2), 32'(py2 >= 11'd480));
         chk("def_fs", 32'(fs2), 32'(k == 0));
         chk("def_nx", 32'(nx2), 32'((px2 == 11'd799) ? 11'd0 : px2 + 11'd1));
         chk("def_ny", 32'(ny2), 32'((px2 == 11'd799) ? py2 + 11'd1 : py2));
         if (ls2) begin
            if (last >= 0) begin
               chk("def_line_period", 32'(k - last), 32'd800);
               chk("def_hs_width", 32'(hs_cnt), 32'd96);
            end
            last = k;
            hs_cnt = 0;
         end
         if (hs2) hs_cnt++;
      end
      def_done = 1'b1;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster timing generator with these features:
  - a clock-enable pixel divider;
  - programmable horizontal/vertical geometry and sync polarity;
  - frame, line and blanking strobes for downstream logic.
- It produces hsync, vsync, data-enable and pixel coordinates for the display path.
- It replaces the fixed 640x480 sync generator.
- All logic runs in the single system clock domain. No derived clocks are generated.

## Interface

Parameters:

- CLK_DIV, 2: system clocks per pixel (≥1); 2 gives 25 MHz pixels from 50 MHz.
- CW, 11: counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- HS_POL, 0: active level of hsync (0 = active-low).
- VS_POL, 0: active level of vsync.

Ports:

- clk50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes the divider, counters and all outputs.
- pix_en  out  1  one-clock strobe per pixel period.
- vga_h_sync  out  1  horizontal sync, polarity HS_POL.
- vga_v_sync  out  1  vertical sync, polarity VS_POL.
- de  out  1  active-video flag, aligned with pix_x/pix_y.
- pix_x  out  CW  x of the pixel currently on the outputs.
- pix_y  out  CW  y of the pixel currently on the outputs.
- next_x  out  CW  x of the next pixel (one pixel ahead), for 1-pixel-latency memory fetch.
- next_y  out  CW  y of the next pixel.
- line_start  out  1  one-clock pulse when the outputs present x=0.
- frame_start  out  1  one-clock pulse when the outputs present (0,0).
- vblank  out  1  level; high while pix_y ≥ V_ACTIVE.

## Operation

Derived totals:

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL is defined the same way from the vertical parameters.
- Defaults give 800 and 525.

Divider:

- div counts 0..CLK_DIV-1 while en=1.
- pix_en=1 exactly when div==CLK_DIV-1 and en=1.
- With CLK_DIV=1, pix_en equals en.

Raster counters:

- The raster counters are cx and cy; next_x/next_y are direct copies of them.
- On each pix_en, cx increments. At H_TOTAL-1 it wraps to 0 and cy increments.
- cy wraps to 0 when it is at V_TOTAL-1 and cx wraps.
- No count of H_TOTAL or V_TOTAL is ever reached.

Output register, on each pix_en, evaluated on pre-increment cx/cy:

- pix_x<=cx and pix_y<=cy.
- de <= (cx<H_ACTIVE)&&(cy<V_ACTIVE).
- hsync is active for cx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], exactly H_SYNC pixels.
- vsync is active for cy in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], exactly V_SYNC lines.
- vblank <= cy≥V_ACTIVE.

Strobes:

- line_start=1 for the single clock following a pix_en that loaded cx==0; 0 otherwise.
- frame_start behaves the same for cx==0&&cy==0.

en=0:

- All registers hold their values.
- pix_en, line_start and frame_start are forced to 0.
- Resuming continues from the held state with no pixel skipped or repeated.

Reset, taking priority over en:

- div, cx, cy, pix_x, pix_y = 0.
- de, pix_en, line_start, frame_start, vblank = 0.
- vga_h_sync = ~HS_POL and vga_v_sync = ~VS_POL, i.e. the inactive level.
- Reset mid-frame restarts the raster at (0,0).
- After reset is released, the first pix_en occurs CLK_DIV clocks later and loads pixel (0,0).

## Timing

- Latency: sync, de and pix_* lag next_* by exactly one pixel period. They update on the same clock edge on which pix_en is high.
- All outputs are registered. next_x/next_y are the counter flops themselves.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks. Line period is H_TOTAL·CLK_DIV clocks.
- hsync and de never change between pix_en edges.

## Structure

- Package vga_timing_pkg holds:
  - default geometry constants for 640x480@60;
  - a 320x240 test geometry;
  - a function computing the required CW from the totals.
- Sub-module pix_clk_en is the CLK_DIV counter. Its inputs are clk50, reset and en; its output is pix_en.
- The top level holds the raster counters and the output register.
- Elaboration check: CW too narrow for the totals, or any zero-width sync or active parameter, is a fatal error.

## Test plan

Small geometry used throughout: H=8/2/3/1 (total 14), V=4/1/2/1 (total 8), CLK_DIV=2, polarity 0.

1. **Reset release:**
   - Stimulus: hold reset 5 clocks, then release.
   - Expected during reset: all outputs at reset values, with syncs at 1.
   - Expected after release: first pix_en at clock 2; frame_start pulses 1 clock after it; pix_x=0, pix_y=0, de=1.
2. **Line timing:**
   - Stimulus: run one line.
   - Expected de: high for pix_x 0..7, low for 8..13.
   - Expected vga_h_sync: low exactly while pix_x ∈ {10,11,12}.
   - Expected period: line_start period is 28 clocks.
3. **Frame timing:**
   - Stimulus: run 2 frames.
   - Expected vga_v_sync: low exactly while pix_y ∈ {5,6}.
   - Expected vblank: high for pix_y 4..7.
   - Expected period: frame_start period is 224 clocks.
   - Expected range: pix_y never reaches 8 and pix_x never reaches 14.
4. **Enable stall:**
   - Stimulus: deassert en for 7 clocks at pix_x=5.
   - Expected: outputs frozen, no pix_en/strobes.
   - Expected on resume: next pixel presented is pix_x=6.
5. **Mid-frame reset:**
   - Stimulus: assert reset at pix_y=3, pix_x=9 for 1 clock.
   - Expected: next cycle shows the reset values; the raster restarts at (0,0) with frame_start.
6. **Defaults and polarity:**
   - Stimulus: CLK_DIV=1 with default geometry and HS_POL=1.
   - Expected: pix_en is continuously high; line period is 800 clocks; frame period is 420000 clocks.
   - Expected hsync: high for 96 pixels at x 656..751.
